// File: rtl/dma_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter_if
// Purpose : bundles the DMA request/grant handshake and the CPU bus-release
//           handshake shared by the DMA engines, the CPU and the arbiter.
// Signals : rx_req        - receive engine bus request (held for the transfer)
//           tx_req        - transmit engine bus request (held for the transfer)
//           rx_grant      - bus granted to the receive engine
//           tx_grant      - bus granted to the transmit engine
//           cpu_bus_req   - request to the CPU to release the system bus
//           cpu_bus_grant - CPU has released the system bus
//           owner         - bus-mux select: 00 CPU, 01 RX, 10 TX
// Modports: master - requesters / CPU side (drives requests and CPU grant)
//           slave  - arbiter side (drives grants, CPU request and owner)
// ---------------------------------------------------------------------------
interface dma_bus_arbiter_if;
    logic       rx_req;
    logic       tx_req;
    logic       rx_grant;
    logic       tx_grant;
    logic       cpu_bus_req;
    logic       cpu_bus_grant;
    logic [1:0] owner;

    modport master (
        output rx_req,
        output tx_req,
        output cpu_bus_grant,
        input  rx_grant,
        input  tx_grant,
        input  cpu_bus_req,
        input  owner
    );

    modport slave (
        input  rx_req,
        input  tx_req,
        input  cpu_bus_grant,
        output rx_grant,
        output tx_grant,
        output cpu_bus_req,
        output owner
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter
// Purpose : arbitrates the system bus between the DMA receive and transmit
//           engines. The CPU is asked to release the bus first; once it does,
//           one engine is granted until it drops its request. Ties between
//           the engines are broken round-robin. Every DMA tenure is followed
//           by one released cycle so the CPU always sees a gap.
// Ports   : i_clk       - system clock, rising edge
//           i_rst       - synchronous active-high reset
//           i_ena       - enables the start of a new arbitration only
//           i_err_clr   - single-cycle pulse clearing both sticky flags
//           o_hold_err  - sticky: a grant lasted MAX_HOLD cycles
//           o_proto_err - sticky: CPU grant fell while a DMA grant was active
//           io_bus      - request/grant handshake (slave modport)
// Params  : MAX_HOLD    - grant length that raises o_hold_err (2..255)
// ---------------------------------------------------------------------------
module dma_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ena,
    input  logic              i_err_clr,
    output logic              o_hold_err,
    output logic              o_proto_err,
    dma_bus_arbiter_if.slave  io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_REQ,
        S_GRANT_RX,
        S_GRANT_TX,
        S_RELEASE
    } state_t;

    localparam logic [7:0] C_HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_last_tx;      // 1: TX was served last, so RX wins the next tie
    logic [7:0] r_hold_cnt;     // completed cycles of the current grant
    logic       r_hold_err;
    logic       r_proto_err;

    logic       w_rx_grant;
    logic       w_tx_grant;
    logic       w_cpu_req;
    logic [1:0] w_owner;
    logic       w_in_grant;
    logic       w_hold_set;
    logic       w_proto_set;

    assign w_in_grant  = (r_state == S_GRANT_RX) || (r_state == S_GRANT_TX);
    // The current grant cycle is number r_hold_cnt+1; flag once it reaches MAX_HOLD.
    assign w_hold_set  = w_in_grant && (r_hold_cnt >= C_HOLD_LAST);
    assign w_proto_set = w_in_grant && !io_bus.cpu_bus_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_last_tx   <= 1'b1;
            r_hold_cnt  <= 8'd0;
            r_hold_err  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_in_grant && (w_next_state == S_RELEASE)) begin
                r_last_tx <= (r_state == S_GRANT_TX);
            end

            // Held at zero outside a grant, so every grant starts counting from 0.
            if (!w_in_grant) begin
                r_hold_cnt <= 8'd0;
            end else if (r_hold_cnt != C_HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end

            // Set has priority over a coincident clear.
            r_hold_err  <= w_hold_set  || (r_hold_err  && !i_err_clr);
            r_proto_err <= w_proto_set || (r_proto_err && !i_err_clr);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rx_grant   = 1'b0;
        w_tx_grant   = 1'b0;
        w_cpu_req    = 1'b0;
        w_owner      = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (i_ena && (io_bus.rx_req || io_bus.tx_req)) begin
                    w_next_state = S_CPU_REQ;
                end
            end
            S_CPU_REQ: begin
                w_cpu_req = 1'b1;
                if (io_bus.cpu_bus_grant) begin
                    if (io_bus.rx_req && io_bus.tx_req) begin
                        w_next_state = r_last_tx ? S_GRANT_RX : S_GRANT_TX;
                    end else if (io_bus.rx_req) begin
                        w_next_state = S_GRANT_RX;
                    end else if (io_bus.tx_req) begin
                        w_next_state = S_GRANT_TX;
                    end else begin
                        // Request withdrawn while waiting: hand the bus straight back.
                        w_next_state = S_RELEASE;
                    end
                end
            end
            S_GRANT_RX: begin
                w_cpu_req  = 1'b1;
                w_rx_grant = 1'b1;
                w_owner    = 2'b01;
                if (!io_bus.rx_req) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_GRANT_TX: begin
                w_cpu_req  = 1'b1;
                w_tx_grant = 1'b1;
                w_owner    = 2'b10;
                if (!io_bus.tx_req) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign io_bus.rx_grant    = w_rx_grant;
    assign io_bus.tx_grant    = w_tx_grant;
    assign io_bus.cpu_bus_req = w_cpu_req;
    assign io_bus.owner       = w_owner;
    assign o_hold_err         = r_hold_err;
    assign o_proto_err        = r_proto_err;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_bus_arbiter
// Purpose : self-checking bench for dma_bus_arbiter. A tenure-level model
//           (who owns the bus, whether the CPU is being asked, whether a
//           cool-down cycle is due, how long the grant has run) predicts every
//           output each cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_dma_bus_arbiter;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic err_clr = 1'b0;
    logic hold_err;
    logic proto_err;

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(.MAX_HOLD(MH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ena       (ena),
        .i_err_clr   (err_clr),
        .o_hold_err  (hold_err),
        .o_proto_err (proto_err),
        .io_bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Tenure model: m_own 0 none / 1 RX / 2 TX; m_ask = CPU being asked;
    // m_cool = one released cycle owed; m_glen = grant cycles already completed.
    int m_own    = 0;
    bit m_ask    = 1'b0;
    bit m_cool   = 1'b0;
    bit m_last_tx = 1'b1;
    int m_glen   = 0;
    bit m_hold   = 1'b0;
    bit m_proto  = 1'b0;

    always @(posedge clk) begin
        bit hs;
        bit ps;
        bit keep;
        if (rst) begin
            m_own = 0; m_ask = 1'b0; m_cool = 1'b0; m_last_tx = 1'b1;
            m_glen = 0; m_hold = 1'b0; m_proto = 1'b0;
        end else begin
            hs = (m_own != 0) && (m_glen + 1 >= MH);
            ps = (m_own != 0) && !bus.cpu_bus_grant;
            m_hold  = hs || (m_hold  && !err_clr);
            m_proto = ps || (m_proto && !err_clr);
            if (m_own != 0) begin
                keep = (m_own == 1) ? bus.rx_req : bus.tx_req;
                if (keep) begin
                    m_glen++;
                end else begin
                    m_last_tx = (m_own == 2);
                    m_own = 0; m_glen = 0; m_cool = 1'b1;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_ask) begin
                if (bus.cpu_bus_grant) begin
                    m_ask = 1'b0;
                    if (bus.rx_req && bus.tx_req) m_own = m_last_tx ? 1 : 2;
                    else if (bus.rx_req)          m_own = 1;
                    else if (bus.tx_req)          m_own = 2;
                    else                          m_cool = 1'b1;
                end
            end else if (ena && (bus.rx_req || bus.tx_req)) begin
                m_ask = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_grant",    bus.rx_grant,    8'(m_own == 1));
            check("tx_grant",    bus.tx_grant,    8'(m_own == 2));
            check("cpu_bus_req", bus.cpu_bus_req, 8'(m_ask || (m_own != 0)));
            check("owner",       bus.owner,       8'(m_own));
            check("hold_err",    hold_err,        8'(m_hold));
            check("proto_err",   proto_err,       8'(m_proto));
            check("grant_excl",  bus.rx_grant & bus.tx_grant, 8'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; err_clr = 1'b0;
        bus.rx_req = 1'b0; bus.tx_req = 1'b0; bus.cpu_bus_grant = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        bus.rx_req = 1'b0; bus.tx_req = 1'b0; bus.cpu_bus_grant = 1'b0;
        cyc(2);
        chk_on = 1'b1;
        check("rst_rx_grant",  bus.rx_grant,    8'd0);
        check("rst_tx_grant",  bus.tx_grant,    8'd0);
        check("rst_cpu_req",   bus.cpu_bus_req, 8'd0);
        check("rst_owner",     bus.owner,       8'd0);
        check("rst_hold_err",  hold_err,        8'd0);
        check("rst_proto_err", proto_err,       8'd0);
        rst = 1'b0;

        // Single RX, CPU grants immediately
        do_reset();
        ena = 1'b1; bus.rx_req = 1'b1; bus.cpu_bus_grant = 1'b1;
        cyc(1); check("s1_c1_cpu_req", bus.cpu_bus_req, 8'd1);
                check("s1_c1_rx_grant", bus.rx_grant, 8'd0);
        cyc(1); check("s1_c2_rx_grant", bus.rx_grant, 8'd1);
                check("s1_c2_owner", bus.owner, 8'd1);
        cyc(4); bus.rx_req = 1'b0;
        cyc(1); check("s1_c7_cpu_req", bus.cpu_bus_req, 8'd0);
                check("s1_c7_owner", bus.owner, 8'd0);
        cyc(1); check("s1_c8_cpu_req", bus.cpu_bus_req, 8'd0);

        // Tie round-robin, no pre-emption, Ena gating
        do_reset();
        ena = 1'b1; bus.rx_req = 1'b1; bus.tx_req = 1'b1; bus.cpu_bus_grant = 1'b1;
        cyc(2); check("s2_c2_rx_grant", bus.rx_grant, 8'd1);
                check("s2_c2_tx_grant", bus.tx_grant, 8'd0);
        cyc(1); bus.rx_req = 1'b0;
        cyc(1); check("s2_c4_release_req", bus.cpu_bus_req, 8'd0);
                check("s2_c4_release_own", bus.owner, 8'd0);
                bus.rx_req = 1'b1;
        cyc(3); check("s2_c7_tx_grant", bus.tx_grant, 8'd1);
                check("s2_c7_owner", bus.owner, 8'd2);
        cyc(1); ena = 1'b0;
        cyc(1); check("s2_c9_tx_hold", bus.tx_grant, 8'd1);
                bus.tx_req = 1'b0;
        cyc(3); check("s2_c12_ena_off", bus.cpu_bus_req, 8'd0);
                ena = 1'b1;
        cyc(2); check("s2_c14_rx_grant", bus.rx_grant, 8'd1);
                bus.rx_req = 1'b0;
        cyc(2);

        // Withdrawn request
        do_reset();
        ena = 1'b1; bus.rx_req = 1'b1;
        cyc(1); bus.rx_req = 1'b0;
                check("s3_c1_cpu_req", bus.cpu_bus_req, 8'd1);
        cyc(2); check("s3_c3_cpu_req", bus.cpu_bus_req, 8'd1);
                bus.cpu_bus_grant = 1'b1;
        cyc(1); check("s3_c4_cpu_req", bus.cpu_bus_req, 8'd0);
                check("s3_c4_rx_grant", bus.rx_grant, 8'd0);
                bus.cpu_bus_grant = 1'b0;
        cyc(1); check("s3_c5_cpu_req", bus.cpu_bus_req, 8'd0);

        // Hold error with MAX_HOLD = 4
        do_reset();
        ena = 1'b1; bus.rx_req = 1'b1; bus.cpu_bus_grant = 1'b1;
        cyc(5); check("s4_c5_hold_err", hold_err, 8'd0);
        cyc(1); check("s4_c6_hold_err", hold_err, 8'd1);
        cyc(4); bus.rx_req = 1'b0;
        cyc(2); check("s4_c12_hold_sticky", hold_err, 8'd1);
                err_clr = 1'b1;
        cyc(1); err_clr = 1'b0;
                check("s4_c13_hold_clr", hold_err, 8'd0);

        // Protocol error, set-beats-clear, reset mid-grant
        do_reset();
        ena = 1'b1; bus.tx_req = 1'b1; bus.cpu_bus_grant = 1'b1;
        cyc(2); check("s5_c2_tx_grant", bus.tx_grant, 8'd1);
                bus.cpu_bus_grant = 1'b0;
        cyc(1); check("s5_c3_proto_err", proto_err, 8'd1);
                check("s5_c3_tx_grant", bus.tx_grant, 8'd1);
                err_clr = 1'b1;
        cyc(1); err_clr = 1'b0;
                check("s5_c4_set_wins", proto_err, 8'd1);
                rst = 1'b1;
        cyc(1); check("s5_c5_rst_tx", bus.tx_grant, 8'd0);
                check("s5_c5_rst_req", bus.cpu_bus_req, 8'd0);
                check("s5_c5_rst_owner", bus.owner, 8'd0);
                check("s5_c5_rst_proto", proto_err, 8'd0);
                rst = 1'b0; bus.rx_req = 1'b1; bus.tx_req = 1'b1; bus.cpu_bus_grant = 1'b1;
        cyc(2); check("s5_c7_rx_first", bus.rx_grant, 8'd1);
                bus.rx_req = 1'b0; bus.tx_req = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
